// File: rtl/uart_rx_word_loader.sv
// Packs UART bytes little-endian into 32-bit words and writes them to sequential
// memory addresses. It also detects an end-of-program marker, times out stale partial words, and flags lost words.
module uart_rx_word_loader #(
    parameter int          ADDR_W    = 14,
    parameter int          ADDR_STEP = 4,
    parameter logic [31:0] EOP_WORD  = 32'h0000_0FFF,
    parameter int          TIMEOUT_W = 24
) (
    input  logic                 i_Clock,
    input  logic                 rst_ni,
    input  logic                 i_Enable,
    input  logic                 i_Rx_DV,
    input  logic [7:0]           i_Rx_Byte,
    input  logic [TIMEOUT_W-1:0] i_Timeout,
    output logic                 o_Wr_Valid,
    input  logic                 i_Wr_Ready,
    output logic [ADDR_W-1:0]    o_Wr_Addr,
    output logic [31:0]          o_Wr_Data,
    output logic                 o_Done,
    output logic                 o_Overrun,
    output logic                 o_Timeout_Err,
    output logic                 o_Busy,
    output logic [1:0]           o_State,
    output logic [1:0]           o_Byte_Idx
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0]    STEP    = ADDR_W'(ADDR_STEP);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    state_t                state_q, state_d;
    logic [1:0]            idx_q;
    logic [23:0]           asm_q;
    logic [TIMEOUT_W-1:0]  cnt_q;
    logic                  wr_valid_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           data_q;
    logic                  overrun_q;
    logic                  tmo_err_q;

    logic        collect;
    logic        byte_en;
    logic        word_done;
    logic [31:0] word;
    logic        is_eop;
    logic        hs;
    logic        load;
    logic        drop;
    logic        timeout_hit;

    // Write port: o_Wr_Valid/o_Wr_Addr/o_Wr_Data stay stable while valid is high until a
    // cycle with i_Wr_Ready=1. Dropping the enable is the only way a write is withdrawn.
    assign collect     = (state_q == COLLECT);
    assign byte_en     = collect && i_Rx_DV;
    assign word_done   = byte_en && (idx_q == 2'd3);
    assign word        = {i_Rx_Byte, asm_q};
    assign is_eop      = (word == EOP_WORD);
    assign hs          = wr_valid_q && i_Wr_Ready;
    assign load        = word_done && !is_eop && (!wr_valid_q || hs);
    assign drop        = word_done && !is_eop && wr_valid_q && !hs;
    assign timeout_hit = collect && (idx_q != 2'd0) && !i_Rx_DV &&
                         (i_Timeout != '0) && (cnt_q == i_Timeout);

    always_ff @(posedge i_Clock or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_Enable) state_d = COLLECT;
            end
            COLLECT: begin
                if (word_done && is_eop) begin
                    state_d = (wr_valid_q && !hs) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (hs) state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        // Disabling wins over every other event in the same cycle.
        if (!i_Enable) state_d = IDLE;
    end

    always_ff @(posedge i_Clock or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q      <= '0;
            asm_q      <= '0;
            cnt_q      <= '0;
            wr_valid_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            overrun_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else if (!i_Enable) begin
            idx_q      <= '0;
            asm_q      <= '0;
            cnt_q      <= '0;
            wr_valid_q <= 1'b0;
            addr_q     <= '0;
            overrun_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            if (hs) begin
                addr_q     <= addr_q + STEP;
                wr_valid_q <= 1'b0;
            end
            // A completing word may refill the register in the same cycle it drains.
            if (load) begin
                wr_valid_q <= 1'b1;
                data_q     <= word;
            end
            if (drop) overrun_q <= 1'b1;

            if (byte_en) begin
                idx_q <= idx_q + 2'd1;
                cnt_q <= '0;
                case (idx_q)
                    2'd0:    asm_q[7:0]   <= i_Rx_Byte;
                    2'd1:    asm_q[15:8]  <= i_Rx_Byte;
                    2'd2:    asm_q[23:16] <= i_Rx_Byte;
                    default: asm_q        <= '0;
                endcase
            end else if (timeout_hit) begin
                idx_q     <= '0;
                asm_q     <= '0;
                cnt_q     <= '0;
                tmo_err_q <= 1'b1;
            end else if (idx_q != 2'd0) begin
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign o_Wr_Valid    = wr_valid_q;
    assign o_Wr_Addr     = addr_q;
    assign o_Wr_Data     = data_q;
    assign o_Done        = (state_q == DONE);
    assign o_Overrun     = overrun_q;
    assign o_Timeout_Err = tmo_err_q;
    assign o_Busy        = (idx_q != 2'd0) || wr_valid_q;
    assign o_State       = state_q;
    assign o_Byte_Idx    = idx_q;

endmodule
